// File: rtl/counter_pkg.sv
// Shared types for the interval scheduler: FSM state encoding and default widths.
package counter_pkg;

    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index,
// and that index moves only when the caller strobes advance.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((int'(last_q) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance && any) begin
            last_d = grant_idx;
        end
    end

    // Reset points last_q at the top index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IDX_W'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Interval scheduler: grants one requester at a time, then runs an external shared
// counter up to the requested length (0 meaning a full wrap) and reports completion.
module counter_sched
    import counter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    pause,
    output logic                    cnt_reset,
    output logic                    cnt_enable,
    input  logic [LEN_W-1:0]        cnt_value,
    input  logic                    cnt_overflow,
    output logic                    busy,
    output logic                    done_valid,
    output logic [$clog2(NREQ)-1:0] done_id,
    output sched_state_t            dbg_state
);

    localparam int IDX_W = $clog2(NREQ);

    // Handshake: a request transfers in the cycle req_valid[i] && req_ready[i];
    // req_ready is only ever raised in IDLE, to exactly one requester.

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             accept;
    logic             target_hit;

    assign accept = !reset && (state_q == IDLE) && grant_any;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // A zero length asks for 2^LEN_W ticks, so completion is the counter's wrap flag.
    assign target_hit = (len_q == '0) ? cnt_overflow : (cnt_value == len_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = grant_idx;
                    len_d   = req_len[int'(grant_idx)*LEN_W +: LEN_W];
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = RUN;
            RUN: begin
                if (target_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
        end
    end

    assign req_ready  = accept ? grant : '0;
    assign cnt_reset  = reset || (state_q == CLEAR);
    assign cnt_enable = !reset && (state_q == RUN) && !pause && !target_hit;
    assign busy       = !reset && (state_q != IDLE);
    assign done_valid = !reset && (state_q == DONE);
    assign done_id    = done_valid ? id_q : '0;
    assign dbg_state  = reset ? IDLE : state_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    a_cnt_exclusive: assert property (@(posedge clk) !(cnt_enable && cnt_reset));
    a_done_pulse: assert property (@(posedge clk) disable iff (reset) done_valid |=> !done_valid);

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: external shared counter, tick-budget reference model,
// and a done-side scoreboard fed at each grant.
module tb_counter_sched;
    import counter_pkg::*;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;
    localparam int IDX_W = 2;
    localparam int WRAP  = 1 << LEN_W;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  pause = 1'b0;
    logic                  cnt_reset, cnt_enable;
    logic [LEN_W-1:0]      cnt_val = '0;
    logic                  cnt_ovf = 1'b0;
    logic                  busy, done_valid;
    logic [IDX_W-1:0]      done_id;
    sched_state_t          dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    counter_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .pause        (pause),
        .cnt_reset    (cnt_reset),
        .cnt_enable   (cnt_enable),
        .cnt_value    (cnt_val),
        .cnt_overflow (cnt_ovf),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .dbg_state    (dbg_state)
    );

    // Shared counter lives outside the scheduler; the wrap flag is sticky until cleared.
    always @(posedge clk) begin
        if (cnt_reset) begin
            cnt_val <= '0;
            cnt_ovf <= 1'b0;
        end else if (cnt_enable) begin
            cnt_val <= cnt_val + 1'b1;
            if (cnt_val == {LEN_W{1'b1}}) cnt_ovf <= 1'b1;
        end
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [IDX_W-1:0] exp_q[$];
    int st_q[$];
    int ln_q[$];
    int grant_log[$];
    logic [NREQ-1:0] hs_vec = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    // One interval at a time: it owes m_len unpaused RUN ticks, then one
    // target-reached cycle, then the done cycle.
    bit m_active = 1'b0;
    int m_last = NREQ - 1;
    int m_start, m_len, m_given, m_paused, m_done_at;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit exp_en, exp_cr, exp_busy, exp_done;
        int w;
        hs_vec = req_ready & req_valid;
        if (!reset && (req_ready != '0)) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
        end
        if (reset) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_done_valid", int'(done_valid), 0);
            chk("rst_done_id", int'(done_id), 0);
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_cnt_enable", int'(cnt_enable), 0);
            chk("rst_cnt_reset", int'(cnt_reset), 1);
            chk("rst_state", int'(dbg_state), int'(IDLE));
            m_active = 1'b0;
            m_last = NREQ - 1;
            exp_q.delete();
            st_q.delete();
            ln_q.delete();
        end else begin
            exp_ready = '0;
            exp_en = 1'b0;
            exp_cr = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (m_active) begin
                exp_busy = 1'b1;
                if (cyc - m_start == 1) begin
                    exp_cr = 1'b1;
                end else if (m_done_at == cyc) begin
                    exp_done = 1'b1;
                end else if (m_given < m_len) begin
                    if (pause) m_paused++;
                    else begin
                        exp_en = 1'b1;
                        m_given++;
                    end
                end else begin
                    m_done_at = cyc + 1;
                end
            end else if (req_valid != '0) begin
                w = winner(req_valid, m_last);
                exp_ready[w] = 1'b1;
                m_last = w;
                m_active = 1'b1;
                m_start = cyc;
                m_len = int'(req_len[w*LEN_W +: LEN_W]);
                if (m_len == 0) m_len = WRAP;
                m_given = 0;
                m_paused = 0;
                m_done_at = -1;
                exp_q.push_back(IDX_W'(w));
                st_q.push_back(cyc);
                ln_q.push_back(m_len);
            end
            chk("req_ready", int'(req_ready), int'(exp_ready));
            chk("cnt_reset", int'(cnt_reset), int'(exp_cr));
            chk("cnt_enable", int'(cnt_enable), int'(exp_en));
            chk("busy", int'(busy), int'(exp_busy));
            chk("done_valid", int'(done_valid), int'(exp_done));
            if (exp_done) m_active = 1'b0;
        end
    end

    // ---------------- done monitor ----------------
    always @(negedge clk) begin
        logic [IDX_W-1:0] e_id;
        int e_st, e_ln;
        if (!reset && done_valid) begin
            if (exp_q.size() == 0) begin
                timeout("done_unexpected");
            end else begin
                e_id = exp_q.pop_front();
                e_st = st_q.pop_front();
                e_ln = ln_q.pop_front();
                chk("done_id", int'(done_id), int'(e_id));
                chk("done_latency", cyc - e_st, 3 + e_ln + m_paused);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input int len);
        int n;
        req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
        req_valid[id] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs_vec[id] && n < 600);
        if (!hs_vec[id]) timeout("issue_accept");
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || m_active || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) timeout("wait_idle");
    endtask

    initial begin
        int n;
        int frozen;
        int fair_exp[6];
        fair_exp = '{0, 1, 2, 3, 0, 1};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // single requester, len 5
        issue(0, 5);
        wait_idle(50);

        // full wrap
        issue(1, 0);
        wait_idle(400);

        // len 10 with seven paused RUN cycles
        issue(3, 10);
        tick();
        frozen = int'(cnt_val);
        pause = 1'b1;
        repeat (7) tick();
        chk("pause_frozen", int'(cnt_val), frozen);
        pause = 1'b0;
        wait_idle(50);

        // fairness: everyone constantly valid with len 1
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'(1);
        req_valid = '1;
        n = 0;
        while (grant_log.size() < 6 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        if (grant_log.size() < 6) timeout("fair_grants");
        else for (int i = 0; i < 6; i++) chk("fair_order", grant_log[i], fair_exp[i]);
        wait_idle(50);

        // reset in the middle of RUN
        issue(0, 8);
        n = 0;
        while (cnt_val != 3 && n < 50) begin
            tick();
            n++;
        end
        if (cnt_val != 3) timeout("reach_cnt3");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done_valid), 0);
        issue(2, 4);
        wait_idle(50);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs_vec[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_len[i*LEN_W +: LEN_W] = ($urandom_range(0, 40) == 0) ? '0 : LEN_W'($urandom_range(1, 12));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 60) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            pause = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 400) == 0);
            tick();
        end
        req_valid = '0;
        pause = 1'b0;
        reset = 1'b0;
        tick();
        wait_idle(600);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter LEN_W, default 8, SHALL set the interval-length and counter width.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  NREQ  SHALL carry a per-requester interval request.
REQ-006 req_len  input  NREQ*LEN_W  SHALL carry the packed per-requester interval length in ticks; requester i uses bits [i*LEN_W +: LEN_W].
REQ-007 req_ready  output  NREQ  SHALL be one-hot or zero and mark the accepted requester.
REQ-008 pause  input  1  SHALL freeze counting while high.
REQ-009 cnt_reset  output  1  SHALL drive the shared counter's reset.
REQ-010 cnt_enable  output  1  SHALL drive the shared counter's enable.
REQ-011 cnt_value  input  LEN_W  SHALL carry the shared counter's registered value.
REQ-012 cnt_overflow  input  1  SHALL carry the shared counter's registered wrap flag.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done_valid  output  1  SHALL pulse for one cycle when an interval completes.
REQ-015 done_id  output  $clog2(NREQ)  SHALL identify the completed requester; valid with done_valid.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN and DONE.
REQ-017 IDLE: req_ready SHALL be asserted to the round-robin winner among req_valid bits whenever any bit is set; on handshake the block SHALL latch the id and req_len, then go to CLEAR.
REQ-018 Round-robin: search SHALL start at last_grant+1 mod NREQ; last_grant SHALL be NREQ-1 after reset, so requester 0 has first priority.
REQ-019 CLEAR: cnt_reset=1 and cnt_enable=0 for exactly one cycle, then go to RUN.
REQ-020 RUN, target nonzero: cnt_enable = !pause && (cnt_value != target); go to DONE in the cycle cnt_value == target.
REQ-021 RUN, target 0: this SHALL mean 2^LEN_W ticks; cnt_enable = !pause && !cnt_overflow; go to DONE in the cycle cnt_overflow == 1.
REQ-022 DONE: done_valid=1 and done_id=latched id for one cycle, then go to IDLE.
REQ-023 Latency: with pause low, handshake at cycle T SHALL give done_valid at T+3+len (len 0 gives T+3+2^LEN_W); each paused RUN cycle SHALL add one cycle.
REQ-024 pause in IDLE, CLEAR or DONE SHALL have no effect.
REQ-025 req_ready SHALL be 0 outside IDLE; a requester SHALL hold req_valid and req_len stable until accepted, and a dropped request SHALL be ignored.
REQ-026 A simultaneous request from the requester that just completed SHALL lose to any other pending requester.
REQ-027 cnt_enable and cnt_reset SHALL never be high in the same cycle.

Reset
REQ-028 While reset is high: state=IDLE, busy=0, done_valid=0, done_id=0, req_ready=0, cnt_enable=0, cnt_reset=1, and last_grant=NREQ-1.
REQ-029 Reset mid-interval SHALL abandon the interval with no done_valid; arbitration SHALL restart from requester 0.

Structure
REQ-030 Shared package counter_pkg SHALL hold the state enum sched_state_t and the LEN_W default constant.
REQ-031 Arbitration SHALL live in sub-module rr_arbiter (request vector, advance strobe -> one-hot grant, index).
REQ-032 The controller SHALL instantiate no counter; bench and top level SHALL connect the shared counter externally.

Verification
REQ-033 Single requester: req 0 with len=5 accepted at T -> cnt_reset at T+1, cnt_enable high T+2..T+6, done_valid with done_id=0 at T+8.
REQ-034 Wrap: len=0 -> exactly 256 enable cycles, done on cnt_overflow, done_valid at T+259.
REQ-035 Fairness: all four requesters constantly valid with len=1 -> grants in the order 0,1,2,3,0,1; each done_id matches its grant.
REQ-036 Pause: len=10, pause high for 7 RUN cycles -> done_valid at T+20; cnt_value frozen while paused.
REQ-037 Reset mid-RUN: reset at cnt_value=3 -> next cycle busy=0 and no done_valid; requester 2 valid afterwards is granted, done_id=2.
REQ-038 Assertions: req_ready at most one-hot, never (cnt_enable && cnt_reset), done_valid never high two cycles in a row.
